// File: rtl/logic_unit_pipe.sv
// Registered eight-op bitwise logic unit with valid/ready handshakes and a chaining accumulator.
// Optional ZF/NF flag registers are built only when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       OP,
  input  logic             ACC,
  input  logic             CLR,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ZF,
  output logic             NF
);

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_drain;
  logic [WIDTH-1:0] w_acc_eff;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  // One-entry pipe: a slot frees up in the same cycle it is drained.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_drain   = r_out_valid && out_ready;

  // CLR zeroes the accumulator operand even for an accept in the same cycle.
  assign w_acc_eff = CLR ? '0 : r_acc;
  assign w_b       = ACC ? w_acc_eff : Y;

  always_comb begin
    w_result = '0;
    case (OP)
      3'b000:  w_result = X & w_b;
      3'b001:  w_result = X | w_b;
      3'b010:  w_result = X ^ w_b;
      3'b011:  w_result = ~(X & w_b);
      3'b100:  w_result = ~(X | w_b);
      3'b101:  w_result = ~(X ^ w_b);
      3'b110:  w_result = ~X;
      default: w_result = X;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_result;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= w_result;
    end else if (CLR) begin
      r_acc <= '0;
    end
  end

  assign OUT       = r_out;
  assign out_valid = r_out_valid;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic r_zf;
  logic r_nf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= 1'b0;
      r_nf <= 1'b0;
    end else if (w_accept) begin
      r_zf <= (w_result == '0);
      r_nf <= w_result[WIDTH-1];
    end
  end

  assign ZF = r_zf;
  assign NF = r_nf;
`else
  assign ZF = 1'b0;
  assign NF = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed cases plus randomized traffic against a
// transaction-level model of the output slot, accumulator and flags.
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [2:0]       OP;
  logic             ACC;
  logic             CLR;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] OUT;
  logic             out_valid;
  logic             out_ready;
  logic             ZF;
  logic             NF;

  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .X         (X),
    .Y         (Y),
    .OP        (OP),
    .ACC       (ACC),
    .CLR       (CLR),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .OUT       (OUT),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ZF        (ZF),
    .NF        (NF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: contents of the output slot and the accumulator.
  logic [WIDTH-1:0] m_out;
  logic             m_valid;
  logic [WIDTH-1:0] m_acc;
  logic             m_zf;
  logic             m_nf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] f_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ones ^ (a & b);
      3'd4:    return ones ^ (a | b);
      3'd5:    return ones ^ (a ^ b);
      3'd6:    return ones ^ a;
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    m_out   = '0;
    m_valid = 1'b0;
    m_acc   = '0;
    m_zf    = 1'b0;
    m_nf    = 1'b0;
  endtask

  // Called one time unit after a rising edge: drive, check in_ready, advance model, check outputs.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [2:0] op, input logic acc, input logic clr, input logic ordy);
    logic             rdy;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    in_valid  = iv;
    X         = x;
    Y         = y;
    OP        = op;
    ACC       = acc;
    CLR       = clr;
    out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    check("in_ready", 32'(in_ready), 32'(rdy));
    b = acc ? (clr ? '0 : m_acc) : y;
    r = f_op(op, x, b);
    if (iv && rdy) begin
      m_out   = r;
      m_valid = 1'b1;
      m_acc   = r;
`ifdef LOGIC_UNIT_FLAGS_EN
      m_zf    = (r == 0);
      m_nf    = r[WIDTH-1];
`endif
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (clr) m_acc = '0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("OUT", 32'(OUT), 32'(m_out));
    check("ZF", 32'(ZF), 32'(m_zf));
    check("NF", 32'(NF), 32'(m_nf));
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, ordy);
  endtask

  logic [WIDTH-1:0] all_ops_exp [8];

  initial begin
    all_ops_exp = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF,
                    16'h000F, 16'hF00F, 16'h0F0F, 16'hF0F0};
    rst_n = 1'b0; in_valid = 1'b0; X = '0; Y = '0; OP = '0;
    ACC = 1'b0; CLR = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_out", 32'(OUT), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_zf", 32'(ZF), 32'h0);
    check("rst_nf", 32'(NF), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // AND basic: result visible for exactly one cycle.
    cycle(1'b1, 16'h00FF, 16'h0F0F, 3'd0, 1'b0, 1'b0, 1'b1);
    check("and_basic", 32'(OUT), 32'h000F);
    idle(1'b1);
    check("and_basic_gone", 32'(out_valid), 32'h0);

    // Backpressure: second offer is held off until the first drains.
    cycle(1'b1, 16'hAAAA, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0);
    check("bp_first", 32'(OUT), 32'hAAAA);
    cycle(1'b1, 16'h1234, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b0);
    check("bp_held", 32'(OUT), 32'hAAAA);
    cycle(1'b1, 16'h1234, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b1);
    check("bp_second", 32'(OUT), 32'h1234);
    idle(1'b1);
    check("bp_drained", 32'(out_valid), 32'h0);

    // Accumulator chain.
    cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0001, 16'hBEEF, 3'd1, 1'b1, 1'b0, 1'b1);
    check("chain1", 32'(OUT), 32'h0001);
    cycle(1'b1, 16'h0002, 16'hBEEF, 3'd1, 1'b1, 1'b0, 1'b1);
    check("chain2", 32'(OUT), 32'h0003);
    cycle(1'b1, 16'h0004, 16'hBEEF, 3'd1, 1'b1, 1'b0, 1'b1);
    check("chain3", 32'(OUT), 32'h0007);
    cycle(1'b1, 16'h00F0, 16'hBEEF, 3'd2, 1'b1, 1'b1, 1'b1);
    check("chain_clr", 32'(OUT), 32'h00F0);

    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'hF0F0, 16'hFF00, 3'(i), 1'b0, 1'b0, 1'b1);
      check($sformatf("op%0d", i), 32'(OUT), 32'(all_ops_exp[i]));
    end

    cycle(1'b1, 16'hFFFF, 16'h0, 3'd6, 1'b0, 1'b0, 1'b1);
    check("not_zero", 32'(OUT), 32'h0000);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("flag_zf_set", 32'(ZF), 32'h1);
`else
    check("flag_zf_off", 32'(ZF), 32'h0);
`endif
    check("flag_nf_clear", 32'(NF), 32'h0);
    cycle(1'b1, 16'h8000, 16'h0, 3'd7, 1'b0, 1'b0, 1'b1);
    check("flag_zf_clear", 32'(ZF), 32'h0);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("flag_nf_set", 32'(NF), 32'h1);
`else
    check("flag_nf_off", 32'(NF), 32'h0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 3'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while a result is held.
    cycle(1'b1, 16'h5A5A, 16'h0, 3'd7, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out", 32'(OUT), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    cycle(1'b1, 16'h0003, 16'h0, 3'd1, 1'b1, 1'b0, 1'b1);
    check("post_rst_acc", 32'(OUT), 32'h0003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
